// File: rtl/count_display_drv_if.sv
// Bus between the FSM counter stage and the display driver: count/skip in,
// BCD result, multiplexed 7-segment lines and skip LED out.
interface count_display_drv_if;
    logic [7:0]  count_in;
    logic        skip_in;
    logic [11:0] bcd_out;
    logic        bcd_valid;
    logic [6:0]  seg_out;
    logic [2:0]  an_out;
    logic        skip_led;

    modport master (
        output count_in,
        output skip_in,
        input  bcd_out,
        input  bcd_valid,
        input  seg_out,
        input  an_out,
        input  skip_led
    );

    modport slave (
        input  count_in,
        input  skip_in,
        output bcd_out,
        output bcd_valid,
        output seg_out,
        output an_out,
        output skip_led
    );
endinterface

// File: rtl/count_display_drv.sv
// Converts the counter value to BCD (sequential double-dabble), scans it onto a
// 3-digit multiplexed 7-segment display and stretches skip events into an LED flash.
module count_display_drv #(
    parameter int SCAN_DIV  = 100000,
    parameter int FLASH_LEN = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    count_display_drv_if.slave bus
);

    localparam int SW = $clog2(SCAN_DIV) + 1;
    localparam int FW = $clog2(FLASH_LEN) + 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_capture;
    logic          r_force_cnv;
    logic [7:0]    r_last_val;
    logic [7:0]    r_bin_sr;
    logic [11:0]   r_bcd_acc;
    logic [11:0]   w_bcd_adj;
    logic [3:0]    r_bit_cnt;
    logic [11:0]   r_bcd_out;
    logic          r_bcd_valid;
    logic [SW-1:0] r_scan_cnt;
    logic [1:0]    r_digit_idx;
    logic [3:0]    w_nib;
    logic          w_blank;
    logic [2:0]    w_an;
    logic [6:0]    w_seg;
    logic          r_skip_prev;
    logic [FW-1:0] r_flash_cnt;

    function automatic logic [11:0] add3_nibbles(input logic [11:0] acc);
        logic [11:0] res;
        for (int i = 0; i < 3; i++) begin
            res[i*4 +: 4] = (acc[i*4 +: 4] >= 4'd5) ? (acc[i*4 +: 4] + 4'd3) : acc[i*4 +: 4];
        end
        return res;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Conversion FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Conversion FSM next-state and capture decision
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_bcd_adj   = add3_nibbles(r_bcd_acc);
        case (r_state)
            IDLE: begin
                if ((bus.count_in != r_last_val) || r_force_cnv) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (r_bit_cnt == 4'd7) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Double-dabble datapath and registered BCD result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_force_cnv <= 1'b1;
            r_last_val  <= 8'd0;
            r_bin_sr    <= 8'd0;
            r_bcd_acc   <= 12'd0;
            r_bit_cnt   <= 4'd0;
            r_bcd_out   <= 12'h000;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        r_last_val  <= bus.count_in;
                        r_force_cnv <= 1'b0;
                        r_bin_sr    <= bus.count_in;
                        r_bcd_acc   <= 12'd0;
                        r_bit_cnt   <= 4'd0;
                    end
                end
                SHIFT: begin
                    r_bcd_acc <= {w_bcd_adj[10:0], r_bin_sr[7]};
                    r_bin_sr  <= {r_bin_sr[6:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                DONE: begin
                    r_bcd_out   <= r_bcd_acc;
                    r_bcd_valid <= 1'b1;
                end
                default: r_bcd_valid <= 1'b0;
            endcase
        end
    end

    // Digit scan timer: each slot lasts SCAN_DIV cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt  <= {SW{1'b0}};
            r_digit_idx <= 2'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt  <= {SW{1'b0}};
            r_digit_idx <= (r_digit_idx == 2'd2) ? 2'd0 : (r_digit_idx + 2'd1);
        end else begin
            r_scan_cnt  <= r_scan_cnt + {{(SW-1){1'b0}}, 1'b1};
        end
    end

    // Digit select, leading-zero blanking and segment decode
    always_comb begin
        w_an    = 3'b111;
        w_nib   = 4'd0;
        w_blank = 1'b1;
        case (r_digit_idx)
            2'd0: begin
                w_an    = 3'b110;
                w_nib   = r_bcd_out[3:0];
                w_blank = 1'b0;
            end
            2'd1: begin
                w_an    = 3'b101;
                w_nib   = r_bcd_out[7:4];
                w_blank = (r_bcd_out[11:8] == 4'd0) && (r_bcd_out[7:4] == 4'd0);
            end
            2'd2: begin
                w_an    = 3'b011;
                w_nib   = r_bcd_out[11:8];
                w_blank = (r_bcd_out[11:8] == 4'd0);
            end
            default: begin
                w_an    = 3'b111;
                w_nib   = 4'd0;
                w_blank = 1'b1;
            end
        endcase
        if (w_blank) begin
            w_seg = 7'b1111111;
        end else begin
            w_seg = seg_decode(w_nib);
        end
    end

    // Skip edge detect and retriggerable flash stretcher
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skip_prev <= 1'b0;
            r_flash_cnt <= {FW{1'b0}};
        end else begin
            r_skip_prev <= bus.skip_in;
            if (bus.skip_in && !r_skip_prev) begin
                r_flash_cnt <= FLASH_LOAD;
            end else if (r_flash_cnt != {FW{1'b0}}) begin
                r_flash_cnt <= r_flash_cnt - {{(FW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.bcd_out   = r_bcd_out;
    assign bus.bcd_valid = r_bcd_valid;
    assign bus.an_out    = w_an;
    assign bus.seg_out   = w_seg;
    assign bus.skip_led  = (r_flash_cnt != {FW{1'b0}});

endmodule

// File: doc/count_display_drv.md
# count_display_drv

Downstream consumer of the FSM counter stage: takes its 8-bit count value and skip-to-five indication, and drives a 3-digit multiplexed 7-segment display plus a skip indicator LED. An 8-bit value is converted to BCD by a sequential double-dabble engine, one bit per cycle. The digits are then time-multiplexed onto shared segment lines, and skip events are stretched into a visible LED flash.

## Interface
- SCAN_DIV, default 100000: clk cycles per digit slot (1 ms at 100 MHz); minimum 2.
- FLASH_LEN, default 25000000: clk cycles skip_led stays high per skip event; minimum 1.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- count_in  in  8  unsigned count value from the counter stage.
- skip_in  in  1  skip-to-five indication from the counter stage, level.
- bcd_out  out  12  registered BCD result {hundreds, tens, ones}.
- bcd_valid  out  1  one-cycle pulse when bcd_out updates.
- seg_out  out  7  active-low segments {g,f,e,d,c,b,a}.
- an_out  out  3  active-low one-hot digit enable; bit0 = ones, bit1 = tens, bit2 = hundreds.
- skip_led  out  1  stretched skip indicator, active-high.

## Operation
- Conversion FSM has three states: IDLE, SHIFT, DONE.
- IDLE captures count_in when `count_in != last_val` or `force_cnv` = 1.
  - On capture: last_val <= count_in, force_cnv <= 0, bin_sr <= count_in, bcd_acc <= 0, bit_cnt <= 0, state -> SHIFT.
- SHIFT, each cycle:
  - Add 3 to every bcd_acc nibble that is >= 5.
  - Shift {bcd_acc, bin_sr} left by 1.
  - bit_cnt++; after the 8th shift, state -> DONE.
- DONE: bcd_out <= bcd_acc, bcd_valid <= 1, state -> IDLE.
- count_in changes during SHIFT/DONE are ignored. The next IDLE compare sees any difference from last_val and converts the current value. The final settled value is always converted.
- Width rule: 8-bit input yields a maximum of 255, which fits 12 bits; no overflow possible.
- Scan logic:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit_idx advances 0 -> 1 -> 2 -> 0.
  - an_out: idx0 = 3'b110, idx1 = 3'b101, idx2 = 3'b011.
- seg_out is combinational decode of the selected bcd_out nibble.
  - Active-low patterns: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Nibble > 9 decodes to blank (cannot occur).
- Leading-zero blanking; a blank digit drives seg_out = 7'b1111111 with its anode still enabled.
  - Hundreds digit is blank when it is 0.
  - Tens digit is blank when hundreds and tens are both 0.
  - Ones digit is never blanked.
- Skip stretch:
  - skip_prev registers skip_in.
  - Rising edge (skip_in = 1, skip_prev = 0) loads flash_cnt <= FLASH_LEN; otherwise flash_cnt decrements while nonzero.
  - skip_led = (flash_cnt != 0).
  - A new rising edge during a flash reloads the counter (retrigger). A held-high level does not retrigger.
- Counter widths are $clog2 of the parameter + 1.

## Timing
- Reset asserted: asynchronous clear, no clock required.
  - State IDLE, force_cnv = 1, last_val = 0.
  - bcd_out = 12'h000, bcd_valid = 0.
  - scan_cnt = 0, digit_idx = 0, an_out = 3'b110, seg_out = 7'b1000000.
  - skip_prev = 0, flash_cnt = 0, skip_led = 0.
- First edge after reset release captures count_in unconditionally, because of force_cnv.
- Conversion latency, with capture edge E0:
  - SHIFT occupies edges E1..E8.
  - DONE at E9 writes bcd_out; bcd_valid is high from E9 to E10.
  - Earliest next capture is E10, so the minimum conversion spacing is 10 cycles.
- Display updates combinationally in the cycle after bcd_out changes. A digit slot lasts exactly SCAN_DIV cycles.
- skip_led rises the cycle after the edge that detects the skip_in rising edge and stays high exactly FLASH_LEN cycles.
- Reset asserted mid-conversion aborts it: no bcd_valid is generated, and conversion restarts from force_cnv after release.

## Test plan
- Reset with count_in = 0:
  - During reset: an_out = 3'b110, seg_out = 7'b1000000, skip_led = 0.
  - After release: bcd_valid pulses at E9 with bcd_out = 12'h000.
- count_in = 8'd255 → bcd_out = 12'h255 and a single bcd_valid 9 edges after capture.
- Mid-conversion change: count_in = 8'd9, then 8'd10 on the 3rd cycle after capture.
  - bcd_out = 12'h009 with a valid pulse, then 12'h010 with a second valid pulse starting capture at E10.
- SCAN_DIV = 4, count_in = 8'd7 → an_out cycles 110, 101, 011, 4 cycles each.
  - seg_out = 7'b1111000 on ones, 7'b1111111 on tens and hundreds.
  - With count_in = 8'd105: tens digit shows 7'b1000000 (not blanked).
- FLASH_LEN = 6:
  - skip_in held high 20 cycles → skip_led high exactly 6 cycles.
  - A second rising edge at flash cycle 3 extends the flash to 3 + 6 cycles.
- rst pulsed for 1 ns mid-SHIFT → outputs clear immediately, no bcd_valid, and reconversion completes 10 cycles after release.
